stream_upsizer: RTL and testbench
=================================

# stream_upsizer

Stream width converter that packs RATIO consecutive narrow beats from an upstream stream into one wide beat. It sits directly upstream of the synchronous stream FIFO (`sfifo`) and drives the FIFO's receive port, so producers with narrow datapaths can fill a wide buffer at full rate. An optional idle-timeout flush keeps partially filled words from stalling indefinitely.

## Interface
Parameters:
- T, logic[31:0], narrow input beat type; W = $bits(T).
- RATIO, 4, input beats per output beat; integer ≥ 2.
- TIMEOUT, 16, idle cycles before a partial word is flushed; integer ≥ 1; used only when the flush feature is compiled in.

Ports:
- clock  input  1  sole clock; all state changes on the posedge.
- reset  input  1  synchronous, active-high reset.
- receiver  stream.receive  data W  narrow input beats (valid/ready/data).
- sender  stream.send  data RATIO*W  wide output beats (valid/ready/data).

## Operation
- State:
  - lane index `idx`, range 0..RATIO-1, width $clog2(RATIO);
  - accumulator `acc`, lanes 0..RATIO-2 of W bits each;
  - registered sender.valid and sender.data.
- Accept: a beat transfers when receiver.valid && receiver.ready.
- Lane order: the first beat of a group goes to lane 0 (bits W-1:0). Beat k goes to lane k (bits (k+1)*W-1 : k*W).
- Non-final beat (idx < RATIO-1):
  - acc lane idx <= receiver.data;
  - idx <= idx+1.
- Final beat (idx == RATIO-1):
  - sender.data <= {receiver.data, acc lanes RATIO-2..0};
  - sender.valid <= 1;
  - idx <= 0.
- Output drain: if no word is loaded this cycle and sender.ready is 1, then sender.valid <= 0.
- receiver.ready, combinational: 1 when (idx != RATIO-1) || !sender.valid || sender.ready.
  - Only the final beat of a group can stall, and only while the output register holds an unconsumed word.
- sender.data is held stable while sender.valid && !sender.ready.
- idx wrap-around is explicit. RATIO need not be a power of two.
- Reset values: sender.valid=0, sender.data=0, idx=0, acc=0, flush counter=0.
- Reset mid-group discards the partial group. Reset with a pending output word discards that word.

## Timing
- Latency: sender.valid rises one cycle after the final beat of a group is accepted.
- Throughput: one input beat per cycle sustained when the consumer holds ready=1, i.e. one wide beat every RATIO cycles.
- Back-to-back groups: if the final beat arrives while sender.valid && sender.ready, the new word replaces the old one in the same edge with no bubble.
- No combinational path from receiver.valid to sender.valid. The only combinational path is sender.ready -> receiver.ready.

## Configuration
- Macro: POWLIB_STREAM_UPSIZER_FLUSH_EN.
- Defined: an idle counter of width $clog2(TIMEOUT+1) is built.
  - Counter clears on reset, on any accepted beat, and on a flush.
  - Counter increments while idx != 0 and no beat is accepted; it saturates at TIMEOUT.
  - Flush condition: counter == TIMEOUT, no beat accepted this cycle, and (!sender.valid || sender.ready).
  - On flush: sender.data <= acc lanes 0..idx-1, with lanes idx..RATIO-1 zero-filled; sender.valid <= 1; idx <= 0.
  - A beat accepted in the same cycle always wins: the counter clears and no flush occurs.
  - If the output is blocked, the counter holds at TIMEOUT until the output frees.
- Not defined: no counter is built and no flush occurs. A partial group waits indefinitely for its remaining beats.

## Test plan
- Basic pack: RATIO=4, T=32b, sender.ready=1, beats 0x11,0x22,0x33,0x44 on consecutive cycles -> one cycle later sender.valid=1, data=0x00000044_00000033_00000022_00000011.
- Back-pressure: sender.ready=0 with a word pending, feed 3 beats then a 4th -> first 3 accepted, receiver.ready=0 on the 4th. Raise sender.ready -> 4th accepted the same cycle and the new word appears next cycle.
- Streaming: 12 beats 1..12 back-to-back, sender.ready=1 -> 3 output words on cycles 5, 9, 13 with no input stall.
- Reset mid-group: 2 beats, assert reset 1 cycle, then 4 beats 0xA..0xD -> single output 0x0000000D_0000000C_0000000B_0000000A, no stale lanes.
- Flush (macro on, TIMEOUT=3): beats 0x5,0x6 then idle -> on the 4th idle cycle sender.valid=1, data=0x00000000_00000000_00000006_00000005. Repeat with a beat arriving on idle cycle 3 -> no flush, counter restarts.
- Flush blocked (macro on): partial group plus sender.ready=0 with a word pending -> flush deferred until ready=1, then emitted next cycle. With the macro off, the same stimulus produces no output.

Source files
------------

// File: rtl/stream_upsizer.sv
// rtl/stream_upsizer.sv - packs RATIO consecutive narrow stream beats into one wide beat
// Optional idle-timeout flush of partial words is built when POWLIB_STREAM_UPSIZER_FLUSH_EN is defined.
module stream_upsizer #(
  parameter type T       = logic [31:0],
  parameter int  RATIO   = 4,
  parameter int  TIMEOUT = 16
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      receiver_valid,
  output logic                      receiver_ready,
  input  logic [$bits(T)-1:0]       receiver_data,
  output logic                      sender_valid,
  input  logic                      sender_ready,
  output logic [RATIO*$bits(T)-1:0] sender_data
);

  localparam int W  = $bits(T);
  localparam int IW = $clog2(RATIO);
  localparam logic [IW-1:0] LAST = IW'(RATIO - 1);

  logic [IW-1:0]           idx;
  logic [RATIO-2:0][W-1:0] acc;
  logic                    accept;
  logic                    last_beat;
  logic                    flush;
  logic [RATIO*W-1:0]      flush_word;

  // Only the group's final beat needs the output register, so only it can stall.
  assign receiver_ready = (idx != LAST) || !sender_valid || sender_ready;
  assign accept         = receiver_valid && receiver_ready;
  assign last_beat      = accept && (idx == LAST);

`ifdef POWLIB_STREAM_UPSIZER_FLUSH_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CMAX = CW'(TIMEOUT);

  logic [CW-1:0] idle_cnt;

  assign flush = (idle_cnt == CMAX) && (idx != '0) && !accept &&
                 (!sender_valid || sender_ready);

  // Saturates at TIMEOUT so a blocked flush fires as soon as the output frees.
  always_ff @(posedge clock) begin
    if (reset || accept || flush) begin
      idle_cnt <= '0;
    end else if ((idx != '0) && (idle_cnt != CMAX)) begin
      idle_cnt <= idle_cnt + CW'(1);
    end
  end

  always_comb begin
    flush_word = '0;
    for (int k = 0; k < RATIO - 1; k++) begin
      if (IW'(k) < idx) begin
        flush_word[k*W +: W] = acc[k];
      end
    end
  end
`else
  assign flush      = 1'b0 && (TIMEOUT > 0);
  assign flush_word = '0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      idx          <= '0;
      acc          <= '0;
      sender_valid <= 1'b0;
      sender_data  <= '0;
    end else begin
      if (accept) begin
        if (last_beat) begin
          idx <= '0;
        end else begin
          idx <= idx + IW'(1);
          for (int k = 0; k < RATIO - 1; k++) begin
            if (idx == IW'(k)) begin
              acc[k] <= receiver_data;
            end
          end
        end
      end else if (flush) begin
        idx <= '0;
      end

      // A new word replaces a word being consumed in the same edge, so no bubble.
      if (last_beat) begin
        sender_data  <= {receiver_data, acc};
        sender_valid <= 1'b1;
      end else if (flush) begin
        sender_data  <= flush_word;
        sender_valid <= 1'b1;
      end else if (sender_ready) begin
        sender_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_stream_upsizer.sv
// tb/tb_stream_upsizer.sv - directed vector bench for stream_upsizer (RATIO=4, 32-bit beats, TIMEOUT=3)
module tb_stream_upsizer;

  logic         clock = 1'b0;
  logic         reset;
  logic         receiver_valid;
  logic         receiver_ready;
  logic [31:0]  receiver_data;
  logic         sender_valid;
  logic         sender_ready;
  logic [127:0] sender_data;

  int n_checks = 0;
  int n_fail   = 0;

  stream_upsizer #(.T(logic [31:0]), .RATIO(4), .TIMEOUT(3)) dut (
    .clock          (clock),
    .reset          (reset),
    .receiver_valid (receiver_valid),
    .receiver_ready (receiver_ready),
    .receiver_data  (receiver_data),
    .sender_valid   (sender_valid),
    .sender_ready   (sender_ready),
    .sender_data    (sender_data)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic         rst;
    logic         rv;
    logic [31:0]  rd;
    logic         sr;
    logic         chk_rr;
    logic         rr;
    logic         sv;
    logic         chk_d;
    logic [127:0] sd;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [127:0] pack4(input logic [31:0] a, b, c, d);
    return {d, c, b, a};
  endfunction

  function automatic void add(input logic rst, rv, input logic [31:0] rd, input logic sr,
                              input logic chk_rr, rr, sv, chk_d, input logic [127:0] sd);
    vec_t v;
    v.rst = rst; v.rv = rv; v.rd = rd; v.sr = sr;
    v.chk_rr = chk_rr; v.rr = rr; v.sv = sv; v.chk_d = chk_d; v.sd = sd;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rst, rv, input logic [31:0] rd, input logic sr);
    reset          = rst;
    receiver_valid = rv;
    receiver_data  = rd;
    sender_ready   = sr;
  endtask

  task automatic advance();
    @(posedge clock);
    #1;
  endtask

  task automatic tick(input logic rst, rv, input logic [31:0] rd, input logic sr);
    drive(rst, rv, rd, sr);
    advance();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic exp_sv;
    drive(1'b1, 1'b0, 32'h0, 1'b1);

    // reset
    add(1, 0, 0,     1, 0, 0, 0, 1, '0);
    add(1, 0, 0,     1, 1, 1, 0, 1, '0);
    // basic pack
    add(0, 1, 'h11,  1, 1, 1, 0, 0, '0);
    add(0, 1, 'h22,  1, 1, 1, 0, 0, '0);
    add(0, 1, 'h33,  1, 1, 1, 0, 0, '0);
    add(0, 1, 'h44,  1, 1, 1, 1, 1, pack4('h11, 'h22, 'h33, 'h44));
    add(0, 0, 0,     1, 1, 1, 0, 0, '0);
    // back-pressure: word pending, final beat of next group stalls
    add(0, 1, 1,     0, 1, 1, 0, 0, '0);
    add(0, 1, 2,     0, 1, 1, 0, 0, '0);
    add(0, 1, 3,     0, 1, 1, 0, 0, '0);
    add(0, 1, 4,     0, 1, 1, 1, 1, pack4(1, 2, 3, 4));
    add(0, 1, 5,     0, 1, 1, 1, 1, pack4(1, 2, 3, 4));
    add(0, 1, 6,     0, 1, 1, 1, 1, pack4(1, 2, 3, 4));
    add(0, 1, 7,     0, 1, 1, 1, 1, pack4(1, 2, 3, 4));
    add(0, 1, 8,     0, 1, 0, 1, 1, pack4(1, 2, 3, 4));
    add(0, 1, 8,     1, 1, 1, 1, 1, pack4(5, 6, 7, 8));
    add(0, 0, 0,     1, 1, 1, 0, 0, '0);
    // reset mid-group discards partial lanes
    add(0, 1, 'hAA,  1, 1, 1, 0, 0, '0);
    add(0, 1, 'hBB,  1, 1, 1, 0, 0, '0);
    add(1, 0, 0,     1, 1, 1, 0, 1, '0);
    add(0, 1, 'hA,   1, 1, 1, 0, 0, '0);
    add(0, 1, 'hB,   1, 1, 1, 0, 0, '0);
    add(0, 1, 'hC,   1, 1, 1, 0, 0, '0);
    add(0, 1, 'hD,   1, 1, 1, 1, 1, pack4('hA, 'hB, 'hC, 'hD));
    add(0, 0, 0,     1, 1, 1, 0, 0, '0);
    // reset with a pending word discards it
    add(0, 1, 'h21,  0, 1, 1, 0, 0, '0);
    add(0, 1, 'h22,  0, 1, 1, 0, 0, '0);
    add(0, 1, 'h23,  0, 1, 1, 0, 0, '0);
    add(0, 1, 'h24,  0, 1, 1, 1, 1, pack4('h21, 'h22, 'h23, 'h24));
    add(1, 0, 0,     0, 1, 1, 0, 1, '0);
    add(0, 0, 0,     1, 1, 1, 0, 0, '0);

    advance();
    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].rv, vecs[i].rd, vecs[i].sr);
      #1;
      if (vecs[i].chk_rr) check($sformatf("vec%0d receiver_ready", i), 128'(receiver_ready), 128'(vecs[i].rr));
      advance();
      check($sformatf("vec%0d sender_valid", i), 128'(sender_valid), 128'(vecs[i].sv));
      if (vecs[i].chk_d) check($sformatf("vec%0d sender_data", i), sender_data, vecs[i].sd);
    end

    // streaming: 12 beats back-to-back, one word every 4 cycles, no stall
    for (int k = 1; k <= 12; k++) begin
      drive(1'b0, 1'b1, 32'(k), 1'b1);
      #1;
      check($sformatf("stream%0d receiver_ready", k), 128'(receiver_ready), 128'(1));
      advance();
      check($sformatf("stream%0d sender_valid", k), 128'(sender_valid), 128'(k % 4 == 0));
      if (k % 4 == 0)
        check($sformatf("stream%0d sender_data", k), sender_data,
              pack4(32'(k - 3), 32'(k - 2), 32'(k - 1), 32'(k)));
    end
    tick(1'b0, 1'b0, 32'h0, 1'b1);
    check("stream drain sender_valid", 128'(sender_valid), 128'(0));

    // idle flush of a two-beat partial group
    tick(1'b1, 1'b0, 32'h0, 1'b1);
    tick(1'b0, 1'b1, 32'h5, 1'b1);
    tick(1'b0, 1'b1, 32'h6, 1'b1);
    for (int n = 1; n <= 6; n++) begin
      tick(1'b0, 1'b0, 32'h0, 1'b1);
`ifdef POWLIB_STREAM_UPSIZER_FLUSH_EN
      exp_sv = (n == 4);
`else
      exp_sv = 1'b0;
`endif
      check($sformatf("flush idle%0d sender_valid", n), 128'(sender_valid), 128'(exp_sv));
      if (exp_sv) check("flush sender_data", sender_data, pack4(5, 6, 0, 0));
    end
`ifdef POWLIB_STREAM_UPSIZER_FLUSH_EN
    for (int k = 1; k <= 4; k++) tick(1'b0, 1'b1, 32'(k + 'h30), 1'b1);
    check("after flush sender_valid", 128'(sender_valid), 128'(1));
    check("after flush lane order", sender_data, pack4('h31, 'h32, 'h33, 'h34));
`endif

    // a beat on idle cycle 3 restarts the idle count
    tick(1'b1, 1'b0, 32'h0, 1'b1);
    tick(1'b0, 1'b1, 32'h5, 1'b1);
    tick(1'b0, 1'b1, 32'h6, 1'b1);
    for (int n = 1; n <= 2; n++) begin
      tick(1'b0, 1'b0, 32'h0, 1'b1);
      check($sformatf("restart idle%0d sender_valid", n), 128'(sender_valid), 128'(0));
    end
    tick(1'b0, 1'b1, 32'h7, 1'b1);
    check("restart beat sender_valid", 128'(sender_valid), 128'(0));
    for (int n = 1; n <= 6; n++) begin
      tick(1'b0, 1'b0, 32'h0, 1'b1);
`ifdef POWLIB_STREAM_UPSIZER_FLUSH_EN
      exp_sv = (n == 4);
`else
      exp_sv = 1'b0;
`endif
      check($sformatf("restart post%0d sender_valid", n), 128'(sender_valid), 128'(exp_sv));
      if (exp_sv) check("restart flush sender_data", sender_data, pack4(5, 6, 7, 0));
    end

    // flush blocked by a pending word until the consumer is ready
    tick(1'b1, 1'b0, 32'h0, 1'b1);
    for (int k = 1; k <= 4; k++) tick(1'b0, 1'b1, 32'(k), 1'b0);
    tick(1'b0, 1'b1, 32'h5, 1'b0);
    tick(1'b0, 1'b1, 32'h6, 1'b0);
    for (int n = 1; n <= 6; n++) begin
      tick(1'b0, 1'b0, 32'h0, 1'b0);
      check($sformatf("blocked%0d sender_valid", n), 128'(sender_valid), 128'(1));
      check($sformatf("blocked%0d sender_data", n), sender_data, pack4(1, 2, 3, 4));
    end
    tick(1'b0, 1'b0, 32'h0, 1'b1);
`ifdef POWLIB_STREAM_UPSIZER_FLUSH_EN
    check("unblocked sender_valid", 128'(sender_valid), 128'(1));
    check("unblocked sender_data", sender_data, pack4(5, 6, 0, 0));
`else
    check("unblocked sender_valid", 128'(sender_valid), 128'(0));
`endif
    for (int n = 1; n <= 4; n++) begin
      tick(1'b0, 1'b0, 32'h0, 1'b1);
      check($sformatf("post-unblock%0d sender_valid", n), 128'(sender_valid), 128'(0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
